// File: rtl/mem_responder_if.sv
// Request/response channel between a load/store requester and mem_responder.
// Both directions use valid/ready. master = requester, slave = memory.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with configurable wait states, one request in flight.
// Define MEM_RESPONDER_RAND_DELAY_EN to add 0..3 LFSR-chosen extra wait cycles per access.
module mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        accept;
  logic        commit;
  logic [4:0]  load_cnt;
  logic        c_wen;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_wmask;
  logic [32:0] c_off;
  logic        c_err;
  logic [AW-1:0] c_idx;
  logic [31:0] rd_word;
  logic [31:0] commit_rdata;

  // req_ready_q is only ever set while in IDLE, so it also qualifies the state.
  assign accept = bus.req_valid & req_ready_q;

`ifdef MEM_RESPONDER_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign load_cnt = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
`else
  assign load_cnt = 5'(LATENCY);
`endif

  // A zero-latency access commits on the accept edge, straight from the bus.
  assign c_wen   = (state_q == IDLE) ? bus.req_wen   : wen_q;
  assign c_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign c_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign c_wmask = (state_q == IDLE) ? bus.req_wmask : wmask_q;

  assign commit = (accept && (load_cnt == 5'd0)) ||
                  ((state_q == WAIT) && (cnt_q == 5'd1));

  // Below-base addresses borrow into bit 32 and so also land above SPAN.
  assign c_off        = {1'b0, c_addr} - {1'b0, BASE_ADDR};
  assign c_err        = (c_addr[1:0] != 2'b00) || (c_off >= SPAN);
  assign c_idx        = c_off[AW+1:2];
  assign commit_rdata = (c_wen || c_err) ? 32'h0 : rd_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (commit && c_wen && !c_err && c_wmask[gi]) begin
          lane_mem[c_idx] <= c_wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[c_idx];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      wen_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wmask_q     <= 4'h0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wen_q       <= bus.req_wen;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            wmask_q     <= bus.req_wmask;
            cnt_q       <= load_cnt;
            req_ready_q <= 1'b0;
            if (commit) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= c_err;
              rsp_rdata_q <= commit_rdata;
            end else begin
              state_q <= WAIT;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 5'd1;
          if (commit) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= c_err;
            rsp_rdata_q <= commit_rdata;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule
